// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//   Sequences an external 8-bit ALU. One encoded instruction is accepted per
//   valid/ready handshake, operands are read from an internal register file
//   and registered onto the ALU inputs. After the ALU's one-clock registered
//   latency the result is written back to the register file and the
//   architectural flags are updated. A host side port loads and inspects
//   registers.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   instr_valid/ready instruction handshake; ready is high only in IDLE
//   instr             {grp, opcode[2:0], rd, rs_a, rs_b}, MSB first
//   reg_we/waddr/wdata host register write (honoured only in IDLE)
//   reg_raddr/rdata   host combinational register read
//   alu_grp/opcode/op1/op2/op3/flags   registered ALU inputs
//   alu_result, alu_flags_in           ALU outputs, valid in WB
//   done_o, err_o     one-cycle retire pulse, err_o marks illegal encodings
//   result_o, flags_o last legal result and architectural flags
//                     {parity, zero, borrow, carry}
// ---------------------------------------------------------------------------
module alu_sequencer #(
  parameter int REG_AW = 3,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [4+3*REG_AW-1:0] instr,
  input  logic                  reg_we,
  input  logic [REG_AW-1:0]     reg_waddr,
  input  logic [DATA_W-1:0]     reg_wdata,
  input  logic [REG_AW-1:0]     reg_raddr,
  output logic [DATA_W-1:0]     reg_rdata,
  output logic                  alu_grp,
  output logic [2:0]            alu_opcode,
  output logic [DATA_W-1:0]     alu_op1,
  output logic [DATA_W-1:0]     alu_op2,
  output logic [DATA_W-1:0]     alu_op3,
  output logic [3:0]            alu_flags,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [3:0]            alu_flags_in,
  output logic                  done_o,
  output logic                  err_o,
  output logic [DATA_W-1:0]     result_o,
  output logic [3:0]            flags_o
);

  localparam int NREG = 1 << REG_AW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] regFile_q [NREG];
  logic [REG_AW-1:0] rd_q;
  logic              aluGrp_q;
  logic [2:0]        aluOpcode_q;
  logic [DATA_W-1:0] aluOp1_q, aluOp2_q, aluOp3_q;
  logic [DATA_W-1:0] result_q;
  logic [3:0]        flags_q;
  logic              done_q, err_q;

  // Instruction field decode
  logic              instrGrp;
  logic [2:0]        instrOpc;
  logic [REG_AW-1:0] instrRd, instrRsA, instrRsB;
  logic              instrLegal;
  logic              accept;
  logic              hostWe;

  assign instrGrp = instr[3*REG_AW+3];
  assign instrOpc = instr[3*REG_AW+2 -: 3];
  assign instrRd  = instr[3*REG_AW-1 -: REG_AW];
  assign instrRsA = instr[2*REG_AW-1 -: REG_AW];
  assign instrRsB = instr[REG_AW-1:0];

  // Arithmetic group has four opcodes, logic/shift group has six
  assign instrLegal = instrGrp ? (instrOpc <= 3'd5) : (instrOpc <= 3'd3);

  assign instr_ready = (state_q == IDLE);
  assign accept      = instr_valid && instr_ready;

  // Host writes only land while idle, so they never collide with writeback
  assign hostWe = reg_we && (state_q == IDLE);

  assign reg_rdata  = regFile_q[reg_raddr];
  assign alu_grp    = aluGrp_q;
  assign alu_opcode = aluOpcode_q;
  assign alu_op1    = aluOp1_q;
  assign alu_op2    = aluOp2_q;
  assign alu_op3    = aluOp3_q;
  assign alu_flags  = flags_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign result_o   = result_q;
  assign flags_o    = flags_q;

  // Next state: illegal instructions retire directly from IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && instrLegal) state_d = ISSUE;
      ISSUE:   state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // All architectural state: operands are latched at accept from the
  // pre-edge register file, so rd aliasing a source is harmless
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      for (int i = 0; i < NREG; i++) regFile_q[i] <= '0;
      rd_q        <= '0;
      aluGrp_q    <= 1'b0;
      aluOpcode_q <= '0;
      aluOp1_q    <= '0;
      aluOp2_q    <= '0;
      aluOp3_q    <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (instrLegal) begin
              rd_q        <= instrRd;
              aluGrp_q    <= instrGrp;
              aluOpcode_q <= instrOpc;
              aluOp1_q    <= regFile_q[instrRsA];
              aluOp2_q    <= regFile_q[instrRsA];
              aluOp3_q    <= regFile_q[instrRsB];
            end else begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end
          end
          if (hostWe) regFile_q[reg_waddr] <= reg_wdata;
        end
        WB: begin
          regFile_q[rd_q] <= alu_result;
          result_q        <= alu_result;
          flags_q         <= alu_flags_in;
          done_q          <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
//   Directed bench for alu_sequencer with a behavioural one-cycle registered
//   ALU. Expected retire values are pushed into a scoreboard when an
//   instruction is issued; a monitor pops and compares on each done_o.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBB = 3'd3;
  localparam logic [2:0] OP_ROL = 3'd4;
  localparam logic [2:0] OP_ROR = 3'd5;

  logic        clk, rst;
  logic        instr_valid, instr_ready;
  logic [12:0] instr;
  logic        reg_we;
  logic [2:0]  reg_waddr, reg_raddr;
  logic [7:0]  reg_wdata, reg_rdata;
  logic        alu_grp;
  logic [2:0]  alu_opcode;
  logic [7:0]  alu_op1, alu_op2, alu_op3;
  logic [3:0]  alu_flags;
  logic [7:0]  alu_result;
  logic [3:0]  alu_flags_in;
  logic        done_o, err_o;
  logic [7:0]  result_o;
  logic [3:0]  flags_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct packed {
    logic        err;
    logic [7:0]  res;
    logic [3:0]  fl;
    logic [31:0] doneCyc;
  } exp_t;

  exp_t sbQ[$];
  exp_t monE;

  alu_sequencer #(.REG_AW(3), .DATA_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .reg_we       (reg_we),
    .reg_waddr    (reg_waddr),
    .reg_wdata    (reg_wdata),
    .reg_raddr    (reg_raddr),
    .reg_rdata    (reg_rdata),
    .alu_grp      (alu_grp),
    .alu_opcode   (alu_opcode),
    .alu_op1      (alu_op1),
    .alu_op2      (alu_op2),
    .alu_op3      (alu_op3),
    .alu_flags    (alu_flags),
    .alu_result   (alu_result),
    .alu_flags_in (alu_flags_in),
    .done_o       (done_o),
    .err_o        (err_o),
    .result_o     (result_o),
    .flags_o      (flags_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: arithmetic updates all flags, logic/shift passes them
  function automatic logic [11:0] aluEval(input logic g, input logic [2:0] o,
                                          input logic [7:0] a1, input logic [7:0] a2,
                                          input logic [7:0] a3, input logic [3:0] fi);
    logic [8:0] t;
    logic [7:0] r;
    logic [3:0] f;
    t = '0;
    r = '0;
    f = fi;
    if (!g) begin
      case (o)
        3'd0:    t = {1'b0, a2} + {1'b0, a3};
        3'd1:    t = {1'b0, a2} + {1'b0, a3} + {8'b0, fi[0]};
        3'd2:    t = {1'b0, a2} - {1'b0, a3};
        default: t = {1'b0, a2} - {1'b0, a3} - {8'b0, fi[1]};
      endcase
      r = t[7:0];
      f = {^r, (r == 8'd0), (o[1] ? t[8] : 1'b0), (o[1] ? 1'b0 : t[8])};
    end else begin
      case (o)
        3'd0:    r = a2 & a3;
        3'd1:    r = a2 | a3;
        3'd2:    r = a2 ^ a3;
        3'd3:    r = ~a2;
        3'd4:    r = {a1[6:0], a1[7]};
        default: r = {a1[0], a1[7:1]};
      endcase
    end
    return {r, f};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) {alu_result, alu_flags_in} <= '0;
    else     {alu_result, alu_flags_in} <= aluEval(alu_grp, alu_opcode, alu_op1, alu_op2, alu_op3, alu_flags);
  end

  function automatic logic [12:0] mk(input logic g, input logic [2:0] o, input logic [2:0] d,
                                     input logic [2:0] a, input logic [2:0] b);
    return {g, o, d, a, b};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: every done_o pulse must match the oldest scoreboard entry
  always @(negedge clk) begin
    if (!rst) begin
      if (done_o) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          monE = sbQ.pop_front();
          checkOutput("retire_err",    {31'd0, err_o},  {31'd0, monE.err});
          checkOutput("retire_result", {24'd0, result_o}, {24'd0, monE.res});
          checkOutput("retire_flags",  {28'd0, flags_o}, {28'd0, monE.fl});
          checkOutput("retire_cycle",  cyc, monE.doneCyc);
        end
      end else if (err_o) begin
        checkOutput("err_without_done", 32'd1, 32'd0);
      end
    end
  end

  task automatic doReset();
    @(negedge clk);
    rst         = 1'b1;
    instr_valid = 1'b0;
    reg_we      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic hostWrite(input logic [2:0] addr, input logic [7:0] data);
    @(negedge clk);
    reg_we    = 1'b1;
    reg_waddr = addr;
    reg_wdata = data;
    @(negedge clk);
    reg_we = 1'b0;
  endtask

  task automatic readReg(input string name, input logic [2:0] addr, input logic [7:0] expected);
    @(negedge clk);
    reg_raddr = addr;
    #1;
    checkOutput(name, {24'd0, reg_rdata}, {24'd0, expected});
  endtask

  task automatic applyStimulus(input logic [12:0] word, input logic expErr,
                               input logic [7:0] expRes, input logic [3:0] expFl);
    exp_t e;
    int   acc;
    @(negedge clk);
    checkOutput("ready_before_issue", {31'd0, instr_ready}, 32'd1);
    instr       = word;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    acc         = cyc;
    instr_valid = 1'b0;
    e.err     = expErr;
    e.res     = expRes;
    e.fl      = expFl;
    e.doneCyc = expErr ? acc : acc + 2;
    sbQ.push_back(e);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 30 && sbQ.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    checkOutput("scoreboard_drained", sbQ.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    int   a, b;
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = '0;
    reg_we      = 1'b0;
    reg_waddr   = '0;
    reg_wdata   = '0;
    reg_raddr   = '0;
    doReset();

    // Reset state
    @(negedge clk);
    #1;
    checkOutput("rst_ready",  {31'd0, instr_ready}, 32'd1);
    checkOutput("rst_done",   {31'd0, done_o}, 32'd0);
    checkOutput("rst_err",    {31'd0, err_o}, 32'd0);
    checkOutput("rst_flags",  {28'd0, flags_o}, 32'd0);
    checkOutput("rst_result", {24'd0, result_o}, 32'd0);
    checkOutput("rst_alu_ops", {8'd0, alu_op1, alu_op2, alu_op3}, 32'd0);
    readReg("rst_r3", 3'd3, 8'h00);

    // ADD with carry out
    hostWrite(3'd1, 8'hF0);
    hostWrite(3'd2, 8'h20);
    applyStimulus(mk(1'b0, OP_ADD, 3'd3, 3'd1, 3'd2), 1'b0, 8'h10, 4'b1001);
    waitDrain();
    readReg("add_r3", 3'd3, 8'h10);

    // SUB with borrow, then SBB consuming it, then an illegal encoding
    doReset();
    hostWrite(3'd1, 8'h05);
    hostWrite(3'd2, 8'h07);
    applyStimulus(mk(1'b0, OP_SUB, 3'd4, 3'd1, 3'd2), 1'b0, 8'hFE, 4'b1010);
    waitDrain();
    applyStimulus(mk(1'b0, OP_SBB, 3'd5, 3'd1, 3'd1), 1'b0, 8'hFF, 4'b0010);
    waitDrain();
    readReg("sub_r4", 3'd4, 8'hFE);
    readReg("sbb_r5", 3'd5, 8'hFF);
    applyStimulus(mk(1'b0, 3'd5, 3'd1, 3'd2, 3'd3), 1'b1, 8'hFF, 4'b0010);
    @(negedge clk);
    checkOutput("illegal_ready",  {31'd0, instr_ready}, 32'd1);
    checkOutput("illegal_alu_op", {28'd0, alu_grp, alu_opcode}, {28'd0, 1'b0, OP_SBB});
    waitDrain();
    readReg("illegal_r1", 3'd1, 8'h05);

    // Rotates pass flags through unchanged
    doReset();
    hostWrite(3'd2, 8'h80);
    hostWrite(3'd6, 8'h81);
    applyStimulus(mk(1'b0, OP_ADD, 3'd0, 3'd2, 3'd2), 1'b0, 8'h00, 4'b0101);
    waitDrain();
    applyStimulus(mk(1'b1, OP_ROL, 3'd7, 3'd6, 3'd6), 1'b0, 8'h03, 4'b0101);
    waitDrain();
    readReg("rol_r7", 3'd7, 8'h03);
    applyStimulus(mk(1'b1, OP_ROR, 3'd7, 3'd6, 3'd6), 1'b0, 8'hC0, 4'b0101);
    waitDrain();
    readReg("ror_r7", 3'd7, 8'hC0);

    // Host write on the accept edge: instruction sees old value, write lands
    hostWrite(3'd1, 8'h11);
    @(negedge clk);
    instr       = mk(1'b0, OP_ADD, 3'd5, 3'd1, 3'd1);
    instr_valid = 1'b1;
    reg_we      = 1'b1;
    reg_waddr   = 3'd1;
    reg_wdata   = 8'h40;
    @(posedge clk);
    #1;
    a           = cyc;
    instr_valid = 1'b0;
    reg_we      = 1'b0;
    e = '{err: 1'b0, res: 8'h22, fl: 4'b0000, doneCyc: a + 2};
    sbQ.push_back(e);
    waitDrain();
    readReg("same_edge_r1", 3'd1, 8'h40);
    readReg("same_edge_r5", 3'd5, 8'h22);

    // Back-to-back with a host write dropped during ISSUE
    hostWrite(3'd1, 8'h11);
    @(negedge clk);
    instr       = mk(1'b0, OP_ADD, 3'd3, 3'd1, 3'd1);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    a = cyc;
    e = '{err: 1'b0, res: 8'h22, fl: 4'b0000, doneCyc: a + 2};
    sbQ.push_back(e);
    @(negedge clk);
    checkOutput("b2b_ready_issue", {31'd0, instr_ready}, 32'd0);
    reg_we    = 1'b1;
    reg_waddr = 3'd1;
    reg_wdata = 8'h55;
    instr     = mk(1'b0, OP_ADD, 3'd4, 3'd1, 3'd3);
    @(negedge clk);
    reg_we = 1'b0;
    checkOutput("b2b_ready_wb", {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    checkOutput("b2b_ready_idle", {31'd0, instr_ready}, 32'd1);
    @(posedge clk);
    #1;
    b           = cyc;
    instr_valid = 1'b0;
    checkOutput("b2b_spacing", b - a, 32'd3);
    e = '{err: 1'b0, res: 8'h33, fl: 4'b0000, doneCyc: b + 2};
    sbQ.push_back(e);
    waitDrain();
    readReg("issue_write_dropped_r1", 3'd1, 8'h11);
    readReg("b2b_r4", 3'd4, 8'h33);

    // Reset during WB aborts the writeback
    doReset();
    hostWrite(3'd1, 8'hF0);
    hostWrite(3'd2, 8'h20);
    @(negedge clk);
    instr       = mk(1'b0, OP_ADD, 3'd3, 3'd1, 3'd2);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_ready",  {31'd0, instr_ready}, 32'd1);
    checkOutput("abort_flags",  {28'd0, flags_o}, 32'd0);
    checkOutput("abort_result", {24'd0, result_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      checkOutput("abort_no_done", {31'd0, done_o}, 32'd0);
    end
    readReg("abort_r3", 3'd3, 8'h00);
    checkOutput("abort_flags_after", {28'd0, flags_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
